// File: rtl/level_decode_engine.sv
// level_decode_engine: CAVLC level decoder (trailing ones + prefix/suffix pairs) with output FIFO.
// Optional LVL_EXT_PREFIX_EN accepts level_prefix 16 (13-bit suffix, +4096 term).
module level_decode_engine #(
  parameter int LEVEL_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [4:0]                TotalCoeff,
  input  logic [1:0]                TrailingOnes,
  input  logic [2:0]                T1Signs,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [4:0]                InPrefix,
  input  logic [15:0]               InSuffix,
  output logic [3:0]                SuffixSize,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic signed [LEVEL_W-1:0] OutLevel,
  output logic                      OutLast,
  output logic                      Busy,
  output logic                      Error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, T1, LVL} state_t;
  state_t state, state_nx;
  logic [4:0] tc, n, pm;
  logic [1:0] t1;
  logic [3:0] sg, sz;
  logic [2:0] sl, sl1, sl_nx;
  logic err, start_ok, full, in_fire, bad, push, pop, first, nlast;
  logic [15:0] suf;
  logic [16:0] lc;
  logic [17:0] mag, thresh;
  logic signed [LEVEL_W-1:0] lvl, push_lvl;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [LEVEL_W:0] mem [FIFO_DEPTH];
  always_comb begin
    start_ok = Start && state == IDLE && TotalCoeff != 5'd0;
    full = cnt == (AW+1)'(FIFO_DEPTH);
    OutValid = cnt != '0;
    pop = OutValid && OutReady;
    InReady = state == LVL && !full;
    in_fire = InValid && InReady;
    sz = (InPrefix == 5'd14 && sl == 3'd0) ? 4'd4 :
         (InPrefix >= 5'd15) ? 4'(InPrefix - 5'd3) : {1'b0, sl};
    SuffixSize = (state == LVL) ? sz : 4'd0;
    suf = InSuffix & ~(16'hFFFF << sz);
    pm = (InPrefix >= 5'd15) ? 5'd15 : InPrefix;
    first = n == {3'b0, t1};
    lc = (17'(pm) << sl) + 17'(suf)
       + ((InPrefix >= 5'd15 && sl == 3'd0) ? 17'd15 : 17'd0)
       + ((first && t1 != 2'd3) ? 17'd2 : 17'd0);
`ifdef LVL_EXT_PREFIX_EN
    bad = InPrefix > 5'd16;
    lc = lc + ((InPrefix == 5'd16) ? 17'd4096 : 17'd0);
`else
    bad = InPrefix > 5'd15;
`endif
    mag = lc[0] ? (18'(lc) + 18'd1) >> 1 : (18'(lc) + 18'd2) >> 1;
    lvl = lc[0] ? -LEVEL_W'(mag) : LEVEL_W'(mag);
    // suffixLength bumps to 1 after any pair, then grows on large magnitudes
    sl1 = (sl == 3'd0) ? 3'd1 : sl;
    thresh = 18'd3 << (sl1 - 3'd1);
    sl_nx = (mag > thresh && sl1 < 3'd6) ? sl1 + 3'd1 : sl1;
    nlast = (n + 5'd1) == tc;
    push = (state == T1 && !full) || (in_fire && !bad);
    push_lvl = (state == T1) ? (sg[n[1:0]] ? -LEVEL_W'(1) : LEVEL_W'(1)) : lvl;
    state_nx = (state == IDLE) ? (start_ok ? (TrailingOnes == 2'd0 ? LVL : T1) : IDLE) :
               (state == T1) ? ((!full && (n + 5'd1) == {3'b0, t1}) ? (tc > {3'b0, t1} ? LVL : IDLE) : T1) :
               (in_fire && (bad || nlast)) ? IDLE : state;
    OutLevel = OutValid ? mem[rp][LEVEL_W-1:0] : '0;
    OutLast = OutValid && mem[rp][LEVEL_W];
    Busy = state != IDLE;
    Error = err;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      tc <= '0;
      t1 <= '0;
      sg <= '0;
      n <= '0;
      sl <= '0;
      err <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        tc <= TotalCoeff;
        t1 <= TrailingOnes;
        sg <= {1'b0, T1Signs};
        n <= '0;
        err <= 1'b0;
        sl <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
      end else if (push) n <= n + 5'd1;
      if (in_fire) begin
        if (bad) err <= 1'b1;
        else sl <= sl_nx;
      end
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge Clk)
    if (push) mem[wp] <= {nlast, push_lvl};
endmodule

// File: tb/tb_level_decode_engine.sv
// tb_level_decode_engine: directed vector table plus hand-written multi-cycle sequences.
module tb_level_decode_engine;
  logic Clk = 1'b0, Reset, Start, InValid, OutReady;
  logic [4:0] TotalCoeff, InPrefix;
  logic [1:0] TrailingOnes;
  logic [2:0] T1Signs;
  logic [15:0] InSuffix;
  logic InReady, OutValid, OutLast, Busy, Error;
  logic [3:0] SuffixSize;
  logic signed [15:0] OutLevel;
  int errs = 0, checks = 0;
  logic signed [15:0] rq_l[$], eq_l[$];
  bit rq_t[$], eq_t[$];
  typedef struct { int kind; int a; int b; int c; int sz; int lvl; int last; } vec_t;
  vec_t tbl [21];

  level_decode_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .TotalCoeff(TotalCoeff),
    .TrailingOnes(TrailingOnes), .T1Signs(T1Signs), .InValid(InValid),
    .InReady(InReady), .InPrefix(InPrefix), .InSuffix(InSuffix),
    .SuffixSize(SuffixSize), .OutValid(OutValid), .OutReady(OutReady),
    .OutLevel(OutLevel), .OutLast(OutLast), .Busy(Busy), .Error(Error)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    #3;
    if (Reset === 1'b0 && OutValid && OutReady) begin
      rq_l.push_back(OutLevel);
      rq_t.push_back(OutLast);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_lvl(input int l, input int t);
    eq_l.push_back(16'(l));
    eq_t.push_back(t != 0);
  endtask

  task automatic start_blk(input int tc, input int t1, input int sg);
    int k = 0;
    while (Busy && k < 200) begin @(negedge Clk); k++; end
    chk("idle_before_start", Busy, 0);
    TotalCoeff = 5'(tc); TrailingOnes = 2'(t1); T1Signs = 3'(sg); Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic send_pair(input int p, input int s, input int sz);
    int k = 0;
    InPrefix = 5'(p); InSuffix = 16'(s); InValid = 1'b1;
    #1;
    while (!InReady && k < 200) begin @(negedge Clk); #1; k++; end
    chk($sformatf("in_ready_p%0d", p), InReady, 1);
    chk($sformatf("suffix_size_p%0d", p), SuffixSize, sz);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic drain_cmp(input string name);
    int k = 0;
    while ((OutValid || Busy) && k < 300) begin @(negedge Clk); k++; end
    repeat (2) @(negedge Clk);
    chk({name, "_count"}, rq_l.size(), eq_l.size());
    for (int i = 0; i < eq_l.size() && i < rq_l.size(); i++) begin
      chk($sformatf("%s_level%0d", name, i), rq_l[i], eq_l[i]);
      chk($sformatf("%s_last%0d", name, i), rq_t[i], eq_t[i]);
    end
    rq_l.delete(); rq_t.delete(); eq_l.delete(); eq_t.delete();
  endtask

  initial begin
    tbl = '{
      '{0, 3, 1, 1, 0, 0, 0}, '{1, 0, 0, 0, 0, -1, 0},
      '{2, 0, 0, 0, 0, 2, 0}, '{2, 1, 1, 0, 1, -2, 1},
      '{0, 2, 0, 0, 0, 0, 0}, '{2, 14, 15, 0, 4, -16, 0}, '{2, 0, 0, 0, 2, 1, 1},
      '{0, 1, 0, 0, 0, 0, 0}, '{2, 15, 0, 0, 12, 17, 1},
      '{0, 4, 3, 5, 0, 0, 0}, '{1, 0, 0, 0, 0, -1, 0}, '{1, 0, 0, 0, 0, 1, 0},
      '{1, 0, 0, 0, 0, -1, 0}, '{2, 3, 0, 0, 0, -2, 1},
      '{0, 3, 0, 0, 0, 0, 0}, '{2, 15, 4095, 0, 12, -2064, 0},
      '{2, 15, 1, 0, 12, -31, 0}, '{2, 0, 5, 0, 3, -3, 1},
      '{0, 2, 2, 2, 0, 0, 0}, '{1, 0, 0, 0, 0, 1, 0}, '{1, 0, 0, 0, 0, -1, 1}
    };
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    TotalCoeff = '0; TrailingOnes = '0; T1Signs = '0; InPrefix = '0; InSuffix = '0;
    repeat (3) @(negedge Clk);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_inready", InReady, 0);
    chk("rst_error", Error, 0);
    chk("rst_outlevel", OutLevel, 0);
    chk("rst_outlast", OutLast, 0);
    chk("rst_suffixsize", SuffixSize, 0);
    Reset = 1'b0;
    @(negedge Clk);

    foreach (tbl[i]) begin
      if (tbl[i].kind == 0) start_blk(tbl[i].a, tbl[i].b, tbl[i].c);
      else begin
        expect_lvl(tbl[i].lvl, tbl[i].last);
        if (tbl[i].kind == 2) send_pair(tbl[i].a, tbl[i].b, tbl[i].sz);
      end
    end
    drain_cmp("table");

    // single pair with prefix 15: Busy falls right after the final push
    OutReady = 1'b0;
    start_blk(1, 0, 0);
    send_pair(15, 0, 12);
    chk("p15_busy_drop", Busy, 0);
    chk("p15_outvalid", OutValid, 1);
    chk("p15_outlevel", OutLevel, 17);
    chk("p15_outlast", OutLast, 1);
    expect_lvl(17, 1);
    OutReady = 1'b1;
    drain_cmp("p15");

    // FIFO fills with OutReady low, backpressure on InReady
    OutReady = 1'b0;
    start_blk(6, 0, 0);
    send_pair(0, 0, 0);
    send_pair(0, 1, 1);
    send_pair(1, 0, 1);
    send_pair(1, 1, 1);
    InPrefix = 5'd2; InSuffix = 16'd0; InValid = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("full_inready", InReady, 0);
    chk("full_outvalid", OutValid, 1);
    chk("full_busy", Busy, 1);
    OutReady = 1'b1;
    send_pair(2, 0, 1);
    send_pair(2, 1, 1);
    expect_lvl(2, 0); expect_lvl(-1, 0); expect_lvl(2, 0);
    expect_lvl(-2, 0); expect_lvl(3, 0); expect_lvl(-3, 1);
    drain_cmp("fifo_full");

    // prefix 16 after one trailing one
    OutReady = 1'b0;
    start_blk(2, 1, 1);
    send_pair(16, 0, 13);
    chk("p16_busy", Busy, 0);
    chk("p16_outvalid", OutValid, 1);
`ifdef LVL_EXT_PREFIX_EN
    chk("p16_error", Error, 0);
    expect_lvl(-1, 0); expect_lvl(2065, 1);
`else
    chk("p16_error", Error, 1);
    expect_lvl(-1, 0);
`endif
    OutReady = 1'b1;
    drain_cmp("p16");
    start_blk(0, 0, 0);
    chk("tc0_busy", Busy, 0);
`ifndef LVL_EXT_PREFIX_EN
    chk("tc0_error_kept", Error, 1);
`endif
    start_blk(1, 0, 0);
    chk("start_clears_error", Error, 0);
    send_pair(0, 0, 0);
    expect_lvl(2, 1);
    drain_cmp("after_err");

    // reset in LVL after two trailing-one pushes
    OutReady = 1'b0;
    start_blk(11, 2, 2);
    repeat (3) @(negedge Clk);
    InPrefix = 5'd0;
    #1;
    chk("sl_init_size", SuffixSize, 1);
    chk("pre_rst_outvalid", OutValid, 1);
    chk("pre_rst_inready", InReady, 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_outvalid", OutValid, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_inready", InReady, 0);
    Reset = 1'b0;
    OutReady = 1'b1;
    @(negedge Clk);
    start_blk(3, 1, 1);
    send_pair(0, 0, 0);
    send_pair(1, 1, 1);
    expect_lvl(-1, 0); expect_lvl(2, 0); expect_lvl(-2, 1);
    drain_cmp("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
